// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: buffers one decoded pair and issues each slot once RAW/WAW hazards clear.
// Latency: a slot issues at least one edge after its pair is accepted; in_ready stays low until every pending slot issues.
module dual_issue_scheduler #(
    parameter int NUM_REGS = 128,
    parameter int LAT_W    = 4,
    parameter int INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first_odd,
    input  logic               flush,
    input  logic               in_vld_even,
    input  logic               in_vld_odd,
    input  logic [INSTR_W-1:0] in_full_instr_even,
    input  logic [INSTR_W-1:0] in_full_instr_odd,
    input  logic [6:0]         in_instr_id_even,
    input  logic [6:0]         in_instr_id_odd,
    input  logic [6:0]         in_reg_dst_even,
    input  logic [6:0]         in_reg_dst_odd,
    input  logic [2:0]         in_unit_id_even,
    input  logic [2:0]         in_unit_id_odd,
    input  logic [LAT_W-1:0]   in_latency_even,
    input  logic [LAT_W-1:0]   in_latency_odd,
    input  logic               in_reg_wr_even,
    input  logic               in_reg_wr_odd,
    input  logic [6:0]         in_ra_addr_even,
    input  logic [6:0]         in_ra_addr_odd,
    input  logic [6:0]         in_rb_addr_even,
    input  logic [6:0]         in_rb_addr_odd,
    input  logic [6:0]         in_rc_addr_even,
    input  logic [6:0]         in_rc_addr_odd,
    input  logic [2:0]         in_src_use_even,
    input  logic [2:0]         in_src_use_odd,
    output logic               out_valid_even,
    output logic               out_valid_odd,
    output logic [INSTR_W-1:0] out_full_instr_even,
    output logic [INSTR_W-1:0] out_full_instr_odd,
    output logic [6:0]         out_instr_id_even,
    output logic [6:0]         out_instr_id_odd,
    output logic [6:0]         out_reg_dst_even,
    output logic [6:0]         out_reg_dst_odd,
    output logic [2:0]         out_unit_id_even,
    output logic [2:0]         out_unit_id_odd,
    output logic [LAT_W-1:0]   out_latency_even,
    output logic [LAT_W-1:0]   out_latency_odd,
    output logic               out_reg_wr_even,
    output logic               out_reg_wr_odd,
    output logic [6:0]         out_ra_addr_even,
    output logic [6:0]         out_ra_addr_odd,
    output logic [6:0]         out_rb_addr_even,
    output logic [6:0]         out_rb_addr_odd,
    output logic [6:0]         out_rc_addr_even,
    output logic [6:0]         out_rc_addr_odd
);

    typedef struct packed {
        logic [INSTR_W-1:0] full_instr;
        logic [6:0]         instr_id;
        logic [6:0]         reg_dst;
        logic [2:0]         unit_id;
        logic [LAT_W-1:0]   latency;
        logic               reg_wr;
        logic [6:0]         ra_addr;
        logic [6:0]         rb_addr;
        logic [6:0]         rc_addr;
    } issue_t;

    typedef struct packed {
        issue_t     ins;
        logic [2:0] src_use;
    } slot_t;

    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    slot_t            in_slot [2];
    slot_t            slot    [2];
    issue_t           out_q   [2];
    logic [1:0]       out_vld;
    logic [1:0]       pend;
    logic [1:0]       pend_nxt;
    logic             older_odd;
    logic [1:0]       slot_ok;
    logic [1:0]       issue;
    logic [1:0]       fire;
    logic             accept;
    logic             old_sel;
    logic             yng_sel;
    logic             old_go;
    logic             yng_go;
    logic             yng_hazard;
    issue_t           old_ins;
    issue_t           yng_ins;
    logic [2:0]       yng_use;
    logic [LAT_W-1:0] cnt [NUM_REGS];

    assign in_slot[0] = {in_full_instr_even, in_instr_id_even, in_reg_dst_even, in_unit_id_even,
                         in_latency_even, in_reg_wr_even, in_ra_addr_even, in_rb_addr_even,
                         in_rc_addr_even, in_src_use_even};
    assign in_slot[1] = {in_full_instr_odd, in_instr_id_odd, in_reg_dst_odd, in_unit_id_odd,
                         in_latency_odd, in_reg_wr_odd, in_ra_addr_odd, in_rb_addr_odd,
                         in_rc_addr_odd, in_src_use_odd};

    // Buffer state is the pending-bit pair: 00 EMPTY, 01/10 HALF, 11 FULL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    always_comb begin
        pend_nxt = pend & ~fire;
        if (flush) begin
            pend_nxt = '0;
        end else if (accept) begin
            pend_nxt = {in_vld_odd, in_vld_even};
        end
    end

    // A slot is issuable when every used source is forwardable next cycle and no older write to dst outlives it.
    always_comb begin
        slot_ok = '0;
        for (int s = 0; s < 2; s++) begin
            slot_ok[s] = pend[s]
                && !(slot[s].src_use[0] && (cnt[slot[s].ins.ra_addr] > LAT_ONE))
                && !(slot[s].src_use[1] && (cnt[slot[s].ins.rb_addr] > LAT_ONE))
                && !(slot[s].src_use[2] && (cnt[slot[s].ins.rc_addr] > LAT_ONE))
                && !(slot[s].ins.reg_wr && (cnt[slot[s].ins.reg_dst] > slot[s].ins.latency));
        end
    end

    always_comb begin
        old_sel    = older_odd;
        yng_sel    = !older_odd;
        old_ins    = slot[old_sel].ins;
        yng_ins    = slot[yng_sel].ins;
        yng_use    = slot[yng_sel].src_use;
        yng_hazard = old_ins.reg_wr &&
                     ((yng_use[0] && (yng_ins.ra_addr == old_ins.reg_dst)) ||
                      (yng_use[1] && (yng_ins.rb_addr == old_ins.reg_dst)) ||
                      (yng_use[2] && (yng_ins.rc_addr == old_ins.reg_dst)) ||
                      (yng_ins.reg_dst == old_ins.reg_dst));
        old_go     = slot_ok[old_sel];
        yng_go     = slot_ok[yng_sel] && (old_go ? !yng_hazard : !pend[old_sel]);
        issue      = older_odd ? {old_go, yng_go} : {yng_go, old_go};
        fire       = flush ? 2'b00 : issue;
        in_ready   = rst && ((pend & ~issue) == 2'b00);
        accept     = in_valid && in_ready && !flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot[0]   <= '0;
            slot[1]   <= '0;
            older_odd <= 1'b0;
        end else if (accept) begin
            slot[0]   <= in_slot[0];
            slot[1]   <= in_slot[1];
            older_odd <= in_first_odd;
        end
    end

    // Younger write is applied last so it wins when both pipes target the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_ONE;
                end
            end
            if (fire[old_sel] && old_ins.reg_wr && (old_ins.latency != '0)) begin
                cnt[old_ins.reg_dst] <= old_ins.latency;
            end
            if (fire[yng_sel] && yng_ins.reg_wr && (yng_ins.latency != '0)) begin
                cnt[yng_ins.reg_dst] <= yng_ins.latency;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld  <= '0;
            out_q[0] <= '0;
            out_q[1] <= '0;
        end else begin
            out_vld  <= fire;
            out_q[0] <= fire[0] ? slot[0].ins : '0;
            out_q[1] <= fire[1] ? slot[1].ins : '0;
        end
    end

    assign out_valid_even      = out_vld[0];
    assign out_valid_odd       = out_vld[1];
    assign out_full_instr_even = out_q[0].full_instr;
    assign out_full_instr_odd  = out_q[1].full_instr;
    assign out_instr_id_even   = out_q[0].instr_id;
    assign out_instr_id_odd    = out_q[1].instr_id;
    assign out_reg_dst_even    = out_q[0].reg_dst;
    assign out_reg_dst_odd     = out_q[1].reg_dst;
    assign out_unit_id_even    = out_q[0].unit_id;
    assign out_unit_id_odd     = out_q[1].unit_id;
    assign out_latency_even    = out_q[0].latency;
    assign out_latency_odd     = out_q[1].latency;
    assign out_reg_wr_even     = out_q[0].reg_wr;
    assign out_reg_wr_odd      = out_q[1].reg_wr;
    assign out_ra_addr_even    = out_q[0].ra_addr;
    assign out_ra_addr_odd     = out_q[1].ra_addr;
    assign out_rb_addr_even    = out_q[0].rb_addr;
    assign out_rb_addr_odd     = out_q[1].rb_addr;
    assign out_rc_addr_even    = out_q[0].rc_addr;
    assign out_rc_addr_odd     = out_q[1].rc_addr;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed hazard scenarios plus randomized traffic against a timestamp scoreboard model.
module tb_dual_issue_scheduler;

    typedef struct packed {
        logic [31:0] full;
        logic [6:0]  id;
        logic [6:0]  dst;
        logic [2:0]  unit;
        logic [3:0]  lat;
        logic        wr;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic [2:0]  src;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_first_odd = 1'b0, flush = 1'b0;
    logic in_vld_even = 1'b0, in_vld_odd = 1'b0;
    ins_t ie = '0, io = '0;
    logic in_ready, out_valid_even, out_valid_odd;
    logic [31:0] out_full_instr_even, out_full_instr_odd;
    logic [6:0]  out_instr_id_even, out_instr_id_odd, out_reg_dst_even, out_reg_dst_odd;
    logic [2:0]  out_unit_id_even, out_unit_id_odd;
    logic [3:0]  out_latency_even, out_latency_odd;
    logic        out_reg_wr_even, out_reg_wr_odd;
    logic [6:0]  out_ra_addr_even, out_ra_addr_odd, out_rb_addr_even, out_rb_addr_odd;
    logic [6:0]  out_rc_addr_even, out_rc_addr_odd;
    logic [74:0] obs_e, obs_o;

    always #5 clk = ~clk;

    dual_issue_scheduler dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first_odd(in_first_odd), .flush(flush),
        .in_vld_even(in_vld_even), .in_vld_odd(in_vld_odd),
        .in_full_instr_even(ie.full), .in_full_instr_odd(io.full),
        .in_instr_id_even(ie.id), .in_instr_id_odd(io.id),
        .in_reg_dst_even(ie.dst), .in_reg_dst_odd(io.dst),
        .in_unit_id_even(ie.unit), .in_unit_id_odd(io.unit),
        .in_latency_even(ie.lat), .in_latency_odd(io.lat),
        .in_reg_wr_even(ie.wr), .in_reg_wr_odd(io.wr),
        .in_ra_addr_even(ie.ra), .in_ra_addr_odd(io.ra),
        .in_rb_addr_even(ie.rb), .in_rb_addr_odd(io.rb),
        .in_rc_addr_even(ie.rc), .in_rc_addr_odd(io.rc),
        .in_src_use_even(ie.src), .in_src_use_odd(io.src),
        .out_valid_even(out_valid_even), .out_valid_odd(out_valid_odd),
        .out_full_instr_even(out_full_instr_even), .out_full_instr_odd(out_full_instr_odd),
        .out_instr_id_even(out_instr_id_even), .out_instr_id_odd(out_instr_id_odd),
        .out_reg_dst_even(out_reg_dst_even), .out_reg_dst_odd(out_reg_dst_odd),
        .out_unit_id_even(out_unit_id_even), .out_unit_id_odd(out_unit_id_odd),
        .out_latency_even(out_latency_even), .out_latency_odd(out_latency_odd),
        .out_reg_wr_even(out_reg_wr_even), .out_reg_wr_odd(out_reg_wr_odd),
        .out_ra_addr_even(out_ra_addr_even), .out_ra_addr_odd(out_ra_addr_odd),
        .out_rb_addr_even(out_rb_addr_even), .out_rb_addr_odd(out_rb_addr_odd),
        .out_rc_addr_even(out_rc_addr_even), .out_rc_addr_odd(out_rc_addr_odd)
    );

    assign obs_e = {out_full_instr_even, out_instr_id_even, out_reg_dst_even, out_unit_id_even,
                    out_latency_even, out_reg_wr_even, out_ra_addr_even, out_rb_addr_even, out_rc_addr_even};
    assign obs_o = {out_full_instr_odd, out_instr_id_odd, out_reg_dst_odd, out_unit_id_odd,
                    out_latency_odd, out_reg_wr_odd, out_ra_addr_odd, out_rb_addr_odd, out_rc_addr_odd};

    // Reference model: buffered pair plus, per register, the edge and latency of its last scoreboard write.
    bit          m_pend [2];
    ins_t        m_slot [2];
    bit          m_odd_old;
    int          sb_l [128];
    int          sb_t [128];
    int          edge_n = 0;
    bit          pre_ready, exp_ready;
    bit          exp_iss [2];
    logic [74:0] exp_f [2];
    int          iss_edge [2];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [74:0] vis(input ins_t x);
        return {x.full, x.id, x.dst, x.unit, x.lat, x.wr, x.ra, x.rb, x.rc};
    endfunction

    // Counter value seen by the decision at edge e: latency minus edges elapsed since the write, floored at 0.
    function automatic int cnt_at(input int r, input int e);
        int v;
        v = sb_l[r] - (e - 1 - sb_t[r]);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit reads(input ins_t y, input logic [6:0] d);
        return (y.src[0] && y.ra == d) || (y.src[1] && y.rb == d) || (y.src[2] && y.rc == d);
    endfunction

    function automatic bit can_go(input ins_t s, input bit p, input int e);
        if (!p) return 1'b0;
        if (s.src[0] && cnt_at(int'(s.ra), e) > 1) return 1'b0;
        if (s.src[1] && cnt_at(int'(s.rb), e) > 1) return 1'b0;
        if (s.src[2] && cnt_at(int'(s.rc), e) > 1) return 1'b0;
        if (s.wr && cnt_at(int'(s.dst), e) > int'(s.lat)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic ins_t mk(input int dst, input int lat, input bit wr,
                                input int ra, input int rb, input int rc, input int src);
        ins_t x;
        x.full = $urandom;
        x.id   = 7'(dst + 1);
        x.dst  = 7'(dst);
        x.unit = 3'(dst);
        x.lat  = 4'(lat);
        x.wr   = wr;
        x.ra   = 7'(ra);
        x.rb   = 7'(rb);
        x.rc   = 7'(rc);
        x.src  = 3'(src);
        return x;
    endfunction

    function automatic ins_t rnd_ins();
        return mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 128; r++) begin
            sb_l[r] = 0;
            sb_t[r] = 0;
        end
        m_pend[0] = 0; m_pend[1] = 0;
        m_slot[0] = '0; m_slot[1] = '0;
        m_odd_old = 0;
    endtask

    // Advance one clock: predict this edge from the model, clock the DUT, then record issue edges.
    task automatic tick();
        int e, o, y;
        bit go [2];
        #1;
        pre_ready = in_ready;
        e = edge_n + 1;
        if (!rst) begin
            model_reset();
            exp_ready = 0;
            for (int s = 0; s < 2; s++) begin exp_iss[s] = 0; exp_f[s] = '0; end
        end else begin
            o = m_odd_old ? 1 : 0;
            y = 1 - o;
            go[o] = can_go(m_slot[o], m_pend[o], e);
            go[y] = can_go(m_slot[y], m_pend[y], e) && (go[o] || !m_pend[o]) &&
                    !(go[o] && m_slot[o].wr &&
                      (reads(m_slot[y], m_slot[o].dst) || m_slot[y].dst == m_slot[o].dst));
            exp_ready = (!m_pend[0] || go[0]) && (!m_pend[1] || go[1]);
            if (flush) begin go[0] = 0; go[1] = 0; end
            for (int s = 0; s < 2; s++) begin
                exp_iss[s] = go[s];
                exp_f[s]   = go[s] ? vis(m_slot[s]) : '0;
            end
            if (go[o] && m_slot[o].wr && m_slot[o].lat != 0) begin
                sb_l[m_slot[o].dst] = int'(m_slot[o].lat); sb_t[m_slot[o].dst] = e;
            end
            if (go[y] && m_slot[y].wr && m_slot[y].lat != 0) begin
                sb_l[m_slot[y].dst] = int'(m_slot[y].lat); sb_t[m_slot[y].dst] = e;
            end
            if (flush) begin
                m_pend[0] = 0; m_pend[1] = 0;
            end else if (in_valid && exp_ready) begin
                m_pend[0] = in_vld_even; m_pend[1] = in_vld_odd;
                m_slot[0] = ie; m_slot[1] = io;
                m_odd_old = in_first_odd;
            end else begin
                for (int s = 0; s < 2; s++) if (go[s]) m_pend[s] = 0;
            end
        end
        @(posedge clk);
        #1;
        edge_n++;
        if (out_valid_even) iss_edge[0] = edge_n;
        if (out_valid_odd) iss_edge[1] = edge_n;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        flush = 0;
        repeat (n) tick();
    endtask

    task automatic push(input ins_t e_in, input ins_t o_in, input bit ve, input bit vo,
                        input bit fo, output int acc);
        ie = e_in; io = o_in; in_vld_even = ve; in_vld_odd = vo; in_first_odd = fo; in_valid = 1;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (pre_ready) begin acc = edge_n; break; end
        end
        in_valid = 0;
    endtask

    task automatic test_reset();
        ie = rnd_ins(); io = rnd_ins(); in_vld_even = 1; in_vld_odd = 1; in_valid = 1;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        checks++; if (out_valid_even !== 1'b0) begin errors++; $display("FAIL reset_vld_even: got %b want 0", out_valid_even); end
        checks++; if (out_valid_odd !== 1'b0) begin errors++; $display("FAIL reset_vld_odd: got %b want 0", out_valid_odd); end
        checks++; if (obs_e !== '0) begin errors++; $display("FAIL reset_fields_even: got %h want 0", obs_e); end
        checks++; if (obs_o !== '0) begin errors++; $display("FAIL reset_fields_odd: got %h want 0", obs_o); end
        in_valid = 0;
        rst = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", in_ready); end
        idle(2);
    endtask

    task automatic test_independent_pair();
        ins_t a, b, c, d;
        int acc, t;
        a = mk(3, 2, 1, 1, 2, 0, 3); b = mk(4, 6, 1, 0, 0, 0, 0);
        push(a, b, 1, 1, 0, acc);
        tick();
        t = edge_n;
        checks++; if (out_valid_even !== 1'b1 || out_valid_odd !== 1'b1) begin errors++; $display("FAIL indep_issue: got %b%b want 11", out_valid_odd, out_valid_even); end
        checks++; if (obs_e !== vis(a)) begin errors++; $display("FAIL indep_fields_even: got %h want %h", obs_e, vis(a)); end
        checks++; if (out_reg_dst_odd !== 7'd4 || out_latency_odd !== 4'd6) begin errors++; $display("FAIL indep_fields_odd: got dst %0d lat %0d want 4 6", out_reg_dst_odd, out_latency_odd); end
        c = mk(30, 1, 0, 3, 0, 0, 1); d = mk(31, 1, 0, 0, 4, 0, 2);
        push(c, d, 1, 1, 0, acc);
        checks++; if (acc !== t + 1) begin errors++; $display("FAIL indep_accept2: got %0d want %0d", acc, t + 1); end
        while (edge_n < t + 8) begin
            tick();
            checks++; if (out_valid_even !== (edge_n == t + 2)) begin errors++; $display("FAIL indep_r3_timing: edge %0d got %b", edge_n - t, out_valid_even); end
            checks++; if (out_valid_odd !== (edge_n == t + 6)) begin errors++; $display("FAIL indep_r4_timing: edge %0d got %b", edge_n - t, out_valid_odd); end
        end
        idle(16);
    endtask

    task automatic test_raw_across();
        int a, acc, t;
        push(mk(5, 4, 1, 0, 0, 0, 0), '0, 1, 0, 0, a);
        t = a + 1;
        push(mk(6, 1, 0, 0, 5, 0, 2), '0, 1, 0, 0, acc);
        checks++; if (acc !== t) begin errors++; $display("FAIL raw_accept: got %0d want %0d", acc, t); end
        while (edge_n < t + 6) begin
            tick();
            checks++; if (out_valid_even !== (edge_n == t + 4)) begin errors++; $display("FAIL raw_issue: edge %0d got %b", edge_n - t, out_valid_even); end
            checks++; if (pre_ready !== (edge_n >= t + 4)) begin errors++; $display("FAIL raw_ready: edge %0d got %b", edge_n - t, pre_ready); end
        end
        idle(16);
    endtask

    task automatic test_intra_pair();
        int a;
        push(mk(7, 3, 1, 1, 1, 1, 0), mk(8, 1, 1, 7, 0, 0, 1), 1, 1, 0, a);
        while (edge_n < a + 6) begin
            tick();
            checks++; if (out_valid_even !== (edge_n == a + 1)) begin errors++; $display("FAIL intra_older: edge %0d got %b", edge_n - a, out_valid_even); end
            checks++; if (out_valid_odd !== (edge_n == a + 4)) begin errors++; $display("FAIL intra_younger: edge %0d got %b", edge_n - a, out_valid_odd); end
        end
        idle(16);
    endtask

    task automatic test_older_blocked();
        int a, acc, t;
        push(mk(10, 5, 1, 0, 0, 0, 0), '0, 1, 0, 0, a);
        t = a + 1;
        push(mk(12, 1, 1, 0, 0, 0, 0), mk(11, 1, 1, 10, 0, 0, 1), 1, 1, 1, acc);
        checks++; if (acc !== t) begin errors++; $display("FAIL order_accept: got %0d want %0d", acc, t); end
        while (edge_n < t + 7) begin
            tick();
            checks++; if (out_valid_even !== (edge_n == t + 5)) begin errors++; $display("FAIL order_younger: edge %0d got %b", edge_n - t, out_valid_even); end
            checks++; if (out_valid_odd !== (edge_n == t + 5)) begin errors++; $display("FAIL order_older: edge %0d got %b", edge_n - t, out_valid_odd); end
        end
        idle(16);
    endtask

    task automatic test_waw();
        int a, acc, acc2, t;
        push(mk(9, 6, 1, 0, 0, 0, 0), '0, 1, 0, 0, a);
        t = a + 1;
        push(mk(9, 2, 1, 0, 0, 0, 0), '0, 1, 0, 0, acc);
        checks++; if (acc !== t) begin errors++; $display("FAIL waw_accept: got %0d want %0d", acc, t); end
        push(mk(13, 1, 0, 9, 0, 0, 1), '0, 1, 0, 0, acc2);
        checks++; if (acc2 !== t + 5) begin errors++; $display("FAIL waw_hold: got %0d want %0d", acc2, t + 5); end
        checks++; if (iss_edge[0] !== t + 5) begin errors++; $display("FAIL waw_issue: got %0d want %0d", iss_edge[0], t + 5); end
        while (edge_n < t + 8) tick();
        checks++; if (iss_edge[0] !== t + 7) begin errors++; $display("FAIL waw_new_latency: got %0d want %0d", iss_edge[0], t + 7); end
        idle(16);
    endtask

    task automatic test_flush();
        int a, acc, acc2, t, odd_before;
        push(mk(12, 8, 1, 0, 0, 0, 0), '0, 1, 0, 0, a);
        t = a + 1;
        push(mk(14, 1, 1, 12, 0, 0, 1), mk(15, 1, 1, 0, 12, 0, 2), 1, 1, 0, acc);
        odd_before = iss_edge[1];
        tick(); tick();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready: got %b want 0", in_ready); end
        flush = 1;
        tick();
        flush = 0;
        checks++; if (out_valid_even !== 1'b0 || out_valid_odd !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b%b want 00", out_valid_odd, out_valid_even); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty_ready: got %b want 1", in_ready); end
        push(mk(16, 1, 0, 12, 0, 0, 1), '0, 1, 0, 0, acc2);
        checks++; if (acc2 !== t + 4) begin errors++; $display("FAIL flush_accept: got %0d want %0d", acc2, t + 4); end
        while (edge_n < t + 10) begin
            tick();
            checks++; if (out_valid_even !== (edge_n == t + 8)) begin errors++; $display("FAIL flush_scoreboard_kept: edge %0d got %b", edge_n - t, out_valid_even); end
        end
        checks++; if (iss_edge[1] !== odd_before) begin errors++; $display("FAIL flush_discard: got %0d want %0d", iss_edge[1], odd_before); end
        idle(16);
    endtask

    task automatic test_reset_mid_stall();
        int a, acc;
        push(mk(20, 9, 1, 0, 0, 0, 0), '0, 1, 0, 0, a);
        push(mk(21, 1, 1, 20, 0, 0, 1), '0, 1, 0, 0, acc);
        checks++; if (out_valid_even !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", out_valid_even); end
        rst = 0;
        #1;
        model_reset();
        checks++; if (out_valid_even !== 1'b0 || obs_e !== '0) begin errors++; $display("FAIL rstmid_outputs: got %b %h want 0", out_valid_even, obs_e); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", in_ready); end
        tick();
        rst = 1;
        push(mk(22, 1, 0, 20, 0, 0, 1), '0, 1, 0, 0, acc);
        tick();
        checks++; if (out_valid_even !== 1'b1 || edge_n !== acc + 1) begin errors++; $display("FAIL rstmid_cnt_cleared: got %b at +%0d want 1 at +1", out_valid_even, edge_n - acc); end
        idle(4);
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 31) == 0);
            in_first_odd = $urandom_range(0, 1);
            in_vld_even  = ($urandom_range(0, 3) != 0);
            in_vld_odd   = ($urandom_range(0, 3) != 0);
            ie = rnd_ins();
            io = rnd_ins();
            tick();
            checks++; if (pre_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready: cycle %0d got %b want %b", k, pre_ready, exp_ready); end
            checks++; if (out_valid_even !== exp_iss[0]) begin errors++; $display("FAIL rnd_vld_even: cycle %0d got %b want %b", k, out_valid_even, exp_iss[0]); end
            checks++; if (out_valid_odd !== exp_iss[1]) begin errors++; $display("FAIL rnd_vld_odd: cycle %0d got %b want %b", k, out_valid_odd, exp_iss[1]); end
            checks++; if (obs_e !== exp_f[0]) begin errors++; $display("FAIL rnd_fields_even: cycle %0d got %h want %h", k, obs_e, exp_f[0]); end
            checks++; if (obs_o !== exp_f[1]) begin errors++; $display("FAIL rnd_fields_odd: cycle %0d got %h want %h", k, obs_o, exp_f[1]); end
        end
        idle(2);
    endtask

    initial begin
        iss_edge[0] = 0;
        iss_edge[1] = 0;
        model_reset();
        test_reset();
        test_independent_pair();
        test_raw_across();
        test_intra_pair();
        test_older_blocked();
        test_waw();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
